// File: rtl/calculator_arbiter_if.sv
// Requester/response bundle for calculator_arbiter.
// master: requester side (drives req_*), slave: arbiter (drives req_ready, rsp_*).
// rsp_div0 exists only when CALC_ARB_DIV0_FLAG_EN is defined.
interface calculator_arbiter_if #(
   parameter int NUM_REQ = 4
);
   localparam int ID_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]   req_valid;
   logic [NUM_REQ-1:0]   req_ready;
   logic [2*NUM_REQ-1:0] req_func;
   logic [8*NUM_REQ-1:0] req_a;
   logic [8*NUM_REQ-1:0] req_b;
   logic                 rsp_valid;
   logic [ID_W-1:0]      rsp_id;
   logic [15:0]          rsp_data;
`ifdef CALC_ARB_DIV0_FLAG_EN
   logic                 rsp_div0;

   modport master (
      output req_valid, req_func, req_a, req_b,
      input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_div0
   );
   modport slave (
      input  req_valid, req_func, req_a, req_b,
      output req_ready, rsp_valid, rsp_id, rsp_data, rsp_div0
   );
`else
   modport master (
      output req_valid, req_func, req_a, req_b,
      input  req_ready, rsp_valid, rsp_id, rsp_data
   );
   modport slave (
      input  req_valid, req_func, req_a, req_b,
      output req_ready, rsp_valid, rsp_id, rsp_data
   );
`endif
endinterface

// File: rtl/calculator_arbiter.sv
// Round-robin arbiter sharing one pipelined calculator among NUM_REQ requesters,
// tagging each op with its requester ID, plus a flush/drain FSM.
// Ports: clk, rst_n (async low); bus (slave: req_valid/ready/func/a/b, rsp_valid/id/data);
// flush in, flush_done pulse out; calc_func/calc_a/calc_b to calculator, calc_out back.
// Optional macro CALC_ARB_DIV0_FLAG_EN adds bus.rsp_div0 carried in the tag pipe.
module calculator_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int LATENCY = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   calculator_arbiter_if.slave  bus,
   input  logic                 flush,
   output logic                 flush_done,
   output logic [1:0]           calc_func,
   output logic [7:0]           calc_a,
   output logic [7:0]           calc_b,
   input  logic [15:0]          calc_out
);
   localparam int ID_W  = $clog2(NUM_REQ);
   // in-flight can reach LATENCY+2 before the first decrement lands
   localparam int CNT_W = $clog2(LATENCY + 3);

   typedef enum logic {RUN, DRAIN} state_t;

   typedef struct packed {
      logic            valid;
`ifdef CALC_ARB_DIV0_FLAG_EN
      logic            div0;
`endif
      logic [ID_W-1:0] id;
   } tag_t;

   state_t           state_q;
   logic [ID_W-1:0]  ptr_q;
   logic [CNT_W-1:0] cnt_q;
   tag_t             tag_q [0:LATENCY];
   tag_t             tag_d;

   logic [NUM_REQ-1:0] gnt;
   logic [ID_W-1:0]    gnt_id;
   logic               gnt_any;
   logic               grant_en;
   logic [1:0]         sel_func;
   logic [7:0]         sel_a;
   logic [7:0]         sel_b;

   function automatic logic [ID_W-1:0] rr_idx(
      input logic [ID_W-1:0] base,
      input int              k
   );
      int s;
      s = int'(base) + k;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      return ID_W'(s);
   endfunction

   // rst_n gating keeps req_ready low while reset is held
   assign grant_en = rst_n && (state_q == RUN) && !flush;

   // Scan downward so the last hit is the nearest one from ptr_q.
   always_comb begin
      gnt     = '0;
      gnt_id  = '0;
      gnt_any = 1'b0;
      if (grant_en) begin
         for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (bus.req_valid[rr_idx(ptr_q, k)]) begin
               gnt_id  = rr_idx(ptr_q, k);
               gnt_any = 1'b1;
            end
         end
      end
      if (gnt_any) gnt[gnt_id] = 1'b1;
   end

   assign bus.req_ready = gnt;
   assign sel_func = bus.req_func[{gnt_id, 1'b0} +: 2];
   assign sel_a    = bus.req_a[{gnt_id, 3'b000} +: 8];
   assign sel_b    = bus.req_b[{gnt_id, 3'b000} +: 8];

   always_comb begin
      tag_d       = '0;
      tag_d.valid = gnt_any;
      tag_d.id    = gnt_id;
`ifdef CALC_ARB_DIV0_FLAG_EN
      tag_d.div0  = gnt_any && (sel_func == 2'b11) && (sel_b == 8'd0);
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= RUN;
         flush_done <= 1'b0;
      end else begin
         flush_done <= 1'b0;
         unique case (state_q)
            RUN: begin
               if (flush) state_q <= DRAIN;
            end
            DRAIN: begin
               if (cnt_q == '0) begin
                  flush_done <= 1'b1;
                  state_q    <= RUN;
               end
            end
            default: state_q <= RUN;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q         <= '0;
         cnt_q         <= '0;
         calc_func     <= '0;
         calc_a        <= '0;
         calc_b        <= '0;
         for (int s = 0; s <= LATENCY; s++) tag_q[s] <= '0;
         bus.rsp_valid <= 1'b0;
         bus.rsp_id    <= '0;
         bus.rsp_data  <= '0;
`ifdef CALC_ARB_DIV0_FLAG_EN
         bus.rsp_div0  <= 1'b0;
`endif
      end else begin
         if (gnt_any) ptr_q <= rr_idx(gnt_id, 1);

         calc_func <= gnt_any ? sel_func : 2'b00;
         calc_a    <= gnt_any ? sel_a : 8'd0;
         calc_b    <= gnt_any ? sel_b : 8'd0;

         tag_q[0] <= tag_d;
         for (int s = 1; s <= LATENCY; s++) tag_q[s] <= tag_q[s-1];

         // last tag stage lines up with calc_out for the same op
         bus.rsp_valid <= tag_q[LATENCY].valid;
         if (tag_q[LATENCY].valid) begin
            bus.rsp_id   <= tag_q[LATENCY].id;
            bus.rsp_data <= calc_out;
`ifdef CALC_ARB_DIV0_FLAG_EN
            bus.rsp_div0 <= tag_q[LATENCY].div0;
`endif
         end

         unique case ({gnt_any, bus.rsp_valid})
            2'b10:   cnt_q <= cnt_q + CNT_W'(1);
            2'b01:   cnt_q <= cnt_q - CNT_W'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end
endmodule

// File: tb/tb_calculator_arbiter.sv
// Testbench for calculator_arbiter: calculator model, scoreboard,
// vector table and hand sequences for flush/reset corner cases.
module tb_calculator_arbiter;
   localparam int NUM_REQ = 4;
   localparam int LATENCY = 2;
   localparam int ID_W    = $clog2(NUM_REQ);

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        flush_done;
   logic [1:0]  calc_func;
   logic [7:0]  calc_a;
   logic [7:0]  calc_b;
   logic [15:0] calc_out;

   int checks = 0;
   int errors = 0;

   calculator_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

   calculator_arbiter #(
      .NUM_REQ (NUM_REQ),
      .LATENCY (LATENCY)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .flush      (flush),
      .flush_done (flush_done),
      .calc_func  (calc_func),
      .calc_a     (calc_a),
      .calc_b     (calc_b),
      .calc_out   (calc_out)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] calc_model(
      input logic [1:0]        f,
      input logic signed [7:0] a,
      input logic signed [7:0] b
   );
      logic signed [15:0] x;
      logic signed [15:0] y;
      x = a;
      y = b;
      case (f)
         2'b00:   return x + y;
         2'b01:   return x - y;
         2'b10:   return x * y;
         default: begin
            if (b == 0) return a[7] ? 16'h8000 : 16'h7FFF;
            return x / y;
         end
      endcase
   endfunction

   logic [15:0] calc_pipe [LATENCY];
   always @(posedge clk) begin
      calc_pipe[0] <= calc_model(calc_func, calc_a, calc_b);
      for (int i = 1; i < LATENCY; i++) calc_pipe[i] <= calc_pipe[i-1];
   end
   assign calc_out = calc_pipe[LATENCY-1];

   typedef struct {
      logic [ID_W-1:0] id;
      logic [15:0]     data;
      logic            div0;
   } exp_t;
   exp_t sb_q[$];

   always @(negedge clk) begin
      if (rst_n) begin
         checks++;
         if (!$onehot0(bus.req_ready)) begin
            errors++;
            $display("FAIL ready_onehot: got %b, want at most one bit", bus.req_ready);
         end
         for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.req_valid[i] && bus.req_ready[i]) begin
               exp_t e;
               e.id   = ID_W'(i);
               e.data = calc_model(bus.req_func[2*i +: 2], bus.req_a[8*i +: 8], bus.req_b[8*i +: 8]);
               e.div0 = (bus.req_func[2*i +: 2] == 2'b11) && (bus.req_b[8*i +: 8] == 8'd0);
               sb_q.push_back(e);
            end
         end
         if (bus.rsp_valid) begin
            checks++;
            if (sb_q.size() == 0) begin
               errors++;
               $display("FAIL sb_unexpected: got rsp id %0d data 0x%0h, want no response",
                        bus.rsp_id, bus.rsp_data);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               if (bus.rsp_id !== e.id || bus.rsp_data !== e.data
`ifdef CALC_ARB_DIV0_FLAG_EN
                   || bus.rsp_div0 !== e.div0
`endif
                  ) begin
                  errors++;
                  $display("FAIL sb_rsp: got id %0d data 0x%0h, want id %0d data 0x%0h div0 %0b",
                           bus.rsp_id, bus.rsp_data, e.id, e.data, e.div0);
               end
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic v, input logic [1:0] f,
                          input logic [7:0] a, input logic [7:0] b);
      bus.req_valid[i]     = v;
      bus.req_func[2*i +: 2] = f;
      bus.req_a[8*i +: 8]  = a;
      bus.req_b[8*i +: 8]  = b;
   endtask

   task automatic set_all();
      for (int i = 0; i < NUM_REQ; i++)
         set_req(i, 1'b1, 2'(i), 8'(10*i + 3), 8'(i + 1));
   endtask

   task automatic clr_all();
      bus.req_valid = '0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      clr_all();
      flush = 1'b0;
      sb_q.delete();
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic wait_idle();
      for (int n = 0; n < 50 && sb_q.size() != 0; n++) tick();
      tick();
      chk("drain_empty", sb_q.size(), 0);
   endtask

   typedef struct {
      int          id;
      logic [1:0]  func;
      logic [7:0]  a;
      logic [7:0]  b;
      logic [15:0] data;
      logic        div0;
   } vec_t;
   vec_t tbl [10];

   initial begin
      int rcnt;
      logic got;

      tbl[0] = '{id:1, func:2'b11, a:8'hFC, b:8'h00, data:16'h8000, div0:1'b1};
      tbl[1] = '{id:1, func:2'b11, a:8'h07, b:8'h00, data:16'h7FFF, div0:1'b1};
      tbl[2] = '{id:0, func:2'b00, a:8'h05, b:8'h03, data:16'h0008, div0:1'b0};
      tbl[3] = '{id:3, func:2'b01, a:8'h9C, b:8'h32, data:16'hFF6A, div0:1'b0};
      tbl[4] = '{id:2, func:2'b10, a:8'h80, b:8'h80, data:16'h4000, div0:1'b0};
      tbl[5] = '{id:0, func:2'b10, a:8'h7F, b:8'hFE, data:16'hFF02, div0:1'b0};
      tbl[6] = '{id:3, func:2'b11, a:8'hF9, b:8'h02, data:16'hFFFD, div0:1'b0};
      tbl[7] = '{id:2, func:2'b00, a:8'h7F, b:8'h7F, data:16'h00FE, div0:1'b0};
      tbl[8] = '{id:1, func:2'b11, a:8'h00, b:8'h00, data:16'h7FFF, div0:1'b1};
      tbl[9] = '{id:0, func:2'b11, a:8'h80, b:8'hFF, data:16'h0080, div0:1'b0};

      bus.req_valid = '0;
      bus.req_func  = '0;
      bus.req_a     = '0;
      bus.req_b     = '0;

      // reset state, with requests pending
      set_all();
      @(negedge clk);
      chk("rst_ready", bus.req_ready, 0);
      chk("rst_calc", {calc_func, calc_a, calc_b}, 0);
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_rsp_id", bus.rsp_id, 0);
      chk("rst_rsp_data", bus.rsp_data, 0);
      chk("rst_flush_done", flush_done, 0);
      do_reset();
      tick();

      // single op with exact timing
      set_req(2, 1'b1, 2'b00, 8'd5, 8'd3);
      @(negedge clk);
      chk("single_ready", bus.req_ready, 4'b0100);
      tick();
      clr_all();
      @(negedge clk);
      chk("single_calc", {calc_func, calc_a, calc_b}, {2'b00, 8'd5, 8'd3});
      tick();
      @(negedge clk);
      chk("single_early2", bus.rsp_valid, 0);
      tick();
      @(negedge clk);
      chk("single_early3", bus.rsp_valid, 0);
      tick();
      @(negedge clk);
      chk("single_rsp_valid", bus.rsp_valid, 1);
      chk("single_rsp_id", bus.rsp_id, 2);
      chk("single_rsp_data", bus.rsp_data, 16'd8);
      tick();
      @(negedge clk);
      chk("single_pulse", bus.rsp_valid, 0);
      chk("single_hold_id", bus.rsp_id, 2);
      chk("single_hold_data", bus.rsp_data, 16'd8);
      tick();

      // vector table
      for (int v = 0; v < 10; v++) begin
         set_req(tbl[v].id, 1'b1, tbl[v].func, tbl[v].a, tbl[v].b);
         @(negedge clk);
         chk($sformatf("tbl%0d_ready", v), bus.req_ready, 1 << tbl[v].id);
         tick();
         clr_all();
         got = 1'b0;
         for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
               got = 1'b1;
               break;
            end
            tick();
         end
         chk($sformatf("tbl%0d_rsp_seen", v), got, 1);
         chk($sformatf("tbl%0d_id", v), bus.rsp_id, tbl[v].id);
         chk($sformatf("tbl%0d_data", v), bus.rsp_data, tbl[v].data);
`ifdef CALC_ARB_DIV0_FLAG_EN
         chk($sformatf("tbl%0d_div0", v), bus.rsp_div0, tbl[v].div0);
`endif
         tick();
      end

      // round-robin fairness from reset
      do_reset();
      set_all();
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (k < 8) chk($sformatf("rr_ready%0d", k), bus.req_ready, 1 << (k % 4));
         chk($sformatf("rr_rsp_valid%0d", k), bus.rsp_valid, k >= 4);
         if (k >= 4) chk($sformatf("rr_rsp_id%0d", k), bus.rsp_id, (k - 4) % 4);
         tick();
         if (k == 7) clr_all();
      end
      wait_idle();

      // flush mid-stream after three grants
      do_reset();
      set_all();
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("fl_grant%0d", k), bus.req_ready, 1 << k);
         tick();
      end
      flush = 1'b1;
      rcnt  = 0;
      @(negedge clk);
      chk("fl_ready_flush", bus.req_ready, 0);
      if (bus.rsp_valid) rcnt++;
      tick();
      flush = 1'b0;
      for (int j = 1; j <= 4; j++) begin
         @(negedge clk);
         chk($sformatf("fl_drain_ready%0d", j), bus.req_ready, 0);
         chk($sformatf("fl_drain_done%0d", j), flush_done, 0);
         if (bus.rsp_valid) rcnt++;
         tick();
      end
      @(negedge clk);
      chk("fl_done", flush_done, 1);
      chk("fl_resume", bus.req_ready, 4'b1000);
      chk("fl_rsp_count", rcnt, 3);
      tick();
      clr_all();
      @(negedge clk);
      chk("fl_done_pulse", flush_done, 0);
      wait_idle();

      // reset with three ops in flight
      do_reset();
      set_all();
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("rm_grant%0d", k), bus.req_ready, 1 << k);
         tick();
      end
      rst_n = 1'b0;
      clr_all();
      sb_q.delete();
      #1;
      chk("rm_calc", {calc_func, calc_a, calc_b}, 0);
      chk("rm_rsp", {bus.rsp_valid, bus.rsp_id, bus.rsp_data}, 0);
      chk("rm_ready", bus.req_ready, 0);
      chk("rm_flush_done", flush_done, 0);
      tick();
      tick();
      rst_n = 1'b1;
      rcnt = 0;
      for (int n = 0; n < 8; n++) begin
         @(negedge clk);
         if (bus.rsp_valid) rcnt++;
         tick();
      end
      chk("rm_no_rsp", rcnt, 0);
      set_all();
      @(negedge clk);
      chk("rm_ptr_zero", bus.req_ready, 4'b0001);
      tick();
      clr_all();
      wait_idle();

      // flush with empty pipeline
      set_req(1, 1'b1, 2'b01, 8'd20, 8'd7);
      flush = 1'b1;
      @(negedge clk);
      chk("fe_ready_flush", bus.req_ready, 0);
      chk("fe_done0", flush_done, 0);
      tick();
      flush = 1'b0;
      @(negedge clk);
      chk("fe_ready_drain", bus.req_ready, 0);
      chk("fe_done1", flush_done, 0);
      tick();
      @(negedge clk);
      chk("fe_done2", flush_done, 1);
      chk("fe_ready_run", bus.req_ready, 4'b0010);
      tick();
      clr_all();
      @(negedge clk);
      chk("fe_done3", flush_done, 0);
      wait_idle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
